picorv32_mem_arbiter: RTL and testbench
=======================================

PICORV32_MEM_ARBITER -- requirements
Module: picorv32_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, meaning downstream wait cycles tolerated per transfer before timeout.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port resetn  in  1  synchronous active-low reset.
REQ-004 SHALL have ports m0_valid/m1_valid  in  1  requester transfer request.
REQ-005 SHALL have ports m0_instr/m1_instr  in  1  request is instruction fetch.
REQ-006 SHALL have ports m0_addr/m1_addr  in  32  byte address.
REQ-007 SHALL have ports m0_wdata/m1_wdata  in  32  write data.
REQ-008 SHALL have ports m0_wstrb/m1_wstrb  in  4  byte write strobes (0 = read).
REQ-009 SHALL have ports m0_ready/m1_ready  out  1  transfer complete to that requester.
REQ-010 SHALL have ports m0_rdata/m1_rdata  out  32  read data to that requester.
REQ-011 SHALL have ports mem_valid, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  out  shared memory request.
REQ-012 SHALL have ports mem_ready  in  1, mem_rdata  in  32  shared memory response.
REQ-013 SHALL have port grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1, 00 = none).
REQ-014 SHALL have port timeout  out  1  sticky wait-limit violation flag.

Function
REQ-015 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-016 In IDLE: only m0_valid -> OWN0; only m1_valid -> OWN1; both -> requester not served last (last_owner register, reset value 1, so m0 wins first tie); neither -> stay.
REQ-017 Arbitration latency SHALL be one cycle: request sampled in IDLE at edge N, mem_valid asserted from cycle N+1.
REQ-018 In OWNk: mem_valid = mk_valid; mem_instr/addr/wdata/wstrb = mk fields, combinationally.
REQ-019 In OWNk: mk_ready = mem_ready && mem_valid; mk_rdata = mem_rdata; the other requester's ready SHALL be 0.
REQ-020 On mem_valid && mem_ready in OWNk: last_owner <= k, next state IDLE (one bubble cycle between transfers, even with both pending).
REQ-021 If mk_valid deasserts in OWNk without handshake: return to IDLE, no transfer, last_owner unchanged.
REQ-022 In IDLE: mem_valid, m0_ready, m1_ready = 0; mem_addr/wdata/wstrb/instr = 0; m*_rdata = mem_rdata.
REQ-023 grant SHALL equal 01 in OWN0, 10 in OWN1, 00 in IDLE.
REQ-024 Wait counter, width $clog2(MAX_WAIT+1), SHALL clear on entering OWNk and increment each cycle mem_valid && !mem_ready, saturating at MAX_WAIT.
REQ-025 timeout SHALL set on the cycle after the counter reaches MAX_WAIT while mem_ready = 0, and hold until reset; the transfer is not aborted.
REQ-026 mem_ready arriving while in IDLE SHALL be ignored.

Reset
REQ-027 With resetn = 0 at an edge: state IDLE, last_owner = 1, wait counter 0, timeout 0, grant 00, all request outputs and readys 0.
REQ-028 Reset mid-transfer SHALL abandon the transfer; no ready is delivered to the owner.

Structure
REQ-029 Package picorv32_mem_arb_pkg SHALL hold the state enum (IDLE/OWN0/OWN1) and the MAX_WAIT default constant.
REQ-030 Wait counter plus sticky flag SHALL be sub-module mem_wait_watchdog (inputs clk, resetn, clear, stall; output timeout).
REQ-031 The block SHALL contain no memory and no clock gating.

Verification
REQ-032 Single m0 read addr 0x100, mem_ready 2 cycles later, rdata 0xDEADBEEF -> m0_ready one cycle, m0_rdata 0xDEADBEEF, grant 01 then 00.
REQ-033 m0 and m1 both assert from reset, immediate mem_ready -> order m0, m1, m0, m1; one IDLE cycle between each.
REQ-034 m1 write addr 0x200, wdata 0x12345678, wstrb 0xF, while m0 idle -> mem outputs match; m0_ready stays 0.
REQ-035 m0 holds, mem_ready withheld 17 cycles with MAX_WAIT 16 -> timeout rises and stays 1 after the later handshake.
REQ-036 resetn low during OWN1 wait -> next cycle grant 00, mem_valid 0, m1_ready never pulses; post-reset tie goes to m0.

Source files
------------

// File: rtl/picorv32_mem_arb_pkg.sv
// Shared types and defaults for the two-master PicoRV32 memory arbiter.
package picorv32_mem_arb_pkg;

    localparam int MAX_WAIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts downstream stall cycles of the current transfer and raises a sticky
// timeout flag once the stall outlasts MAX_WAIT; the transfer itself is never aborted.
module mem_wait_watchdog
    import picorv32_mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic stall,
    output logic timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    // Counter saturates at LIMIT; a further stall cycle at the limit trips the flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (clear) begin
                wait_cnt <= '0;
            end else if (stall && (wait_cnt != LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (stall && (wait_cnt == LIMIT)) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter letting two PicoRV32-style native memory masters share one
// memory port, with a one-cycle IDLE bubble between transfers.
module picorv32_mem_arbiter
    import picorv32_mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  grant,
    output logic        timeout
);

    arb_state_t state, state_next;
    logic       last_owner, last_owner_next;
    logic       wd_clear, wd_stall;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
        end
    end

    // On a tie the master that was not served last wins; a withdrawn request
    // leaves last_owner alone so fairness only tracks completed transfers.
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        mem_valid       = 1'b0;
        mem_instr       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        m0_ready        = 1'b0;
        m1_ready        = 1'b0;
        grant           = 2'b00;

        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_next = last_owner ? OWN0 : OWN1;
                end else if (m0_valid) begin
                    state_next = OWN0;
                end else if (m1_valid) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                grant     = 2'b01;
                mem_valid = m0_valid;
                mem_instr = m0_instr;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_wstrb = m0_wstrb;
                m0_ready  = mem_ready && m0_valid;
                if (m0_valid && mem_ready) begin
                    last_owner_next = 1'b0;
                    state_next      = IDLE;
                end else if (!m0_valid) begin
                    state_next = IDLE;
                end
            end
            OWN1: begin
                grant     = 2'b10;
                mem_valid = m1_valid;
                mem_instr = m1_instr;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_wstrb = m1_wstrb;
                m1_ready  = mem_ready && m1_valid;
                if (m1_valid && mem_ready) begin
                    last_owner_next = 1'b1;
                    state_next      = IDLE;
                end else if (!m1_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    assign wd_clear = (state == IDLE) && (state_next != IDLE);
    assign wd_stall = mem_valid && !mem_ready;

    mem_wait_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (wd_clear),
        .stall   (wd_stall),
        .timeout (timeout)
    );

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Scoreboard bench for picorv32_mem_arbiter: expected transfers are queued as
// stimulus is issued and popped by a monitor at every memory handshake.
module tb_picorv32_mem_arbiter;

    localparam int MAX_WAIT = 16;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  grant;
    logic        timeout;

    picorv32_mem_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0_valid  (m0_valid),
        .m0_instr  (m0_instr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_ready  (m0_ready),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_instr  (m1_instr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_ready  (m1_ready),
        .m1_rdata  (m1_rdata),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .grant     (grant),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        owner;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_item;
    int   hs_cycles[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cycle        = 0;
    int   mem_latency  = 0;
    int   resp_cnt     = 0;
    int   m0_ready_cnt = 0;
    logic force_ready  = 1'b0;
    logic m0_ready_seen = 1'b0;
    logic m1_ready_seen = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic push_exp(input logic owner, input logic instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic [31:0] rdata);
        exp_t e;
        e.owner = owner;
        e.instr = instr;
        e.addr  = addr;
        e.wdata = wdata;
        e.wstrb = wstrb;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cycle++;

    // Memory model: fixed per-address read data, ready after mem_latency wait cycles.
    always @(posedge clk) begin
        #2;
        if (!resetn) begin
            mem_ready = 1'b0;
            resp_cnt  = 0;
        end else if (force_ready) begin
            mem_ready = 1'b1;
        end else if (mem_valid) begin
            if (resp_cnt >= mem_latency) begin
                mem_ready = 1'b1;
                case (mem_addr)
                    32'h0000_0100: mem_rdata = 32'hDEAD_BEEF;
                    32'h0000_0200: mem_rdata = 32'hCAFE_F00D;
                    32'h0000_0300: mem_rdata = 32'h1111_2222;
                    32'h0000_0400: mem_rdata = 32'h3333_4444;
                    32'h0000_0304: mem_rdata = 32'h5555_6666;
                    32'h0000_0404: mem_rdata = 32'h7777_8888;
                    default:       mem_rdata = mem_addr ^ 32'hFFFF_0000;
                endcase
            end else begin
                mem_ready = 1'b0;
                resp_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            resp_cnt  = 0;
        end
    end

    // Monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (m0_ready) begin
            m0_ready_seen = 1'b1;
            m0_ready_cnt++;
        end
        if (m1_ready) m1_ready_seen = 1'b1;
        if (resetn && mem_valid && mem_ready) begin
            hs_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_handshake: got grant %b addr 0x%08h, want no transfer",
                         grant, mem_addr);
            end else begin
                exp_item = exp_q.pop_front();
                check_output("hs_grant", 32'(grant), exp_item.owner ? 32'h2 : 32'h1);
                check_output("hs_instr", 32'(mem_instr), 32'(exp_item.instr));
                check_output("hs_addr", mem_addr, exp_item.addr);
                check_output("hs_wdata", mem_wdata, exp_item.wdata);
                check_output("hs_wstrb", 32'(mem_wstrb), 32'(exp_item.wstrb));
                check_output("hs_owner_ready", 32'(exp_item.owner ? m1_ready : m0_ready), 32'h1);
                check_output("hs_other_ready", 32'(exp_item.owner ? m0_ready : m1_ready), 32'h0);
                check_output("hs_rdata", exp_item.owner ? m1_rdata : m0_rdata, exp_item.rdata);
            end
        end
    end

    // Drives one master's request and holds it until that master sees ready.
    task automatic apply_stimulus(input int m, input logic instr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb);
        int waited = 0;
        if (m == 0) begin
            m0_valid = 1'b1; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end else begin
            m1_valid = 1'b1; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end
        forever begin
            @(negedge clk);
            if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) break;
            waited++;
            if (waited > 200) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL transfer_timeout_m%0d: got no ready, want ready within 200 cycles", m);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (m == 0) begin
            m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        end else begin
            m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got simulation still running, want finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        resetn    = 1'b0;
        m0_valid  = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid  = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_grant", 32'(grant), 32'h0);
        check_output("reset_mem_valid", 32'(mem_valid), 32'h0);
        check_output("reset_m0_ready", 32'(m0_ready), 32'h0);
        check_output("reset_m1_ready", 32'(m1_ready), 32'h0);
        check_output("reset_timeout", 32'(timeout), 32'h0);
        check_output("reset_mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1 resetn = 1'b1;

        // Single m0 read with two wait states; grant appears one cycle after the request.
        $display("[TB] single m0 read");
        mem_latency  = 2;
        m0_ready_cnt = 0;
        push_exp(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        fork
            apply_stimulus(0, 1'b0, 32'h100, 32'h0, 4'h0);
            begin
                @(negedge clk);
                check_output("latency_grant_idle", 32'(grant), 32'h0);
                check_output("latency_mem_valid_idle", 32'(mem_valid), 32'h0);
                @(negedge clk);
                check_output("latency_grant_own0", 32'(grant), 32'h1);
                check_output("latency_mem_valid_own0", 32'(mem_valid), 32'h1);
            end
        join
        @(negedge clk);
        check_output("post_read_grant", 32'(grant), 32'h0);
        check_output("m0_ready_pulses", 32'(m0_ready_cnt), 32'h1);

        // m1 write while m0 stays quiet.
        $display("[TB] m1 write");
        mem_latency   = 1;
        m0_ready_seen = 1'b0;
        push_exp(1'b1, 1'b0, 32'h200, 32'h1234_5678, 4'hF, 32'hCAFE_F00D);
        @(posedge clk); #1;
        apply_stimulus(1, 1'b0, 32'h200, 32'h1234_5678, 4'hF);
        check_output("write_m0_ready_quiet", 32'(m0_ready_seen), 32'h0);

        // Both masters requesting from reset alternate with one bubble each.
        $display("[TB] alternating masters from reset");
        mem_latency = 0;
        @(posedge clk); #1 resetn = 1'b0;
        push_exp(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 32'h1111_2222);
        push_exp(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 32'h3333_4444);
        push_exp(1'b0, 1'b1, 32'h304, 32'h0, 4'h0, 32'h5555_6666);
        push_exp(1'b1, 1'b0, 32'h404, 32'h0, 4'h0, 32'h7777_8888);
        hs_cycles.delete();
        fork
            begin
                apply_stimulus(0, 1'b1, 32'h300, 32'h0, 4'h0);
                apply_stimulus(0, 1'b1, 32'h304, 32'h0, 4'h0);
            end
            begin
                apply_stimulus(1, 1'b0, 32'h400, 32'h0, 4'h0);
                apply_stimulus(1, 1'b0, 32'h404, 32'h0, 4'h0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 resetn = 1'b1;
            end
        join
        check_output("alt_handshake_count", 32'(hs_cycles.size()), 32'h4);
        for (int i = 1; i < hs_cycles.size(); i++) begin
            check_output("alt_bubble_gap", 32'(hs_cycles[i] - hs_cycles[i-1]), 32'h2);
        end

        // Stray mem_ready in IDLE must not reach either master.
        $display("[TB] stray ready and withdrawn request");
        @(posedge clk); #1 force_ready = 1'b1;
        @(negedge clk);
        check_output("idle_ready_m0", 32'(m0_ready), 32'h0);
        check_output("idle_ready_m1", 32'(m1_ready), 32'h0);
        check_output("idle_ready_mem_valid", 32'(mem_valid), 32'h0);
        @(posedge clk); #1 force_ready = 1'b0;

        // m0 withdraws before a handshake; last_owner stays m1 so m0 wins the next tie.
        mem_latency = 5;
        m0_valid = 1'b1; m0_addr = 32'h500;
        @(posedge clk); #1 m0_valid = 1'b0; m0_addr = '0;
        @(posedge clk);
        @(negedge clk);
        check_output("withdraw_grant", 32'(grant), 32'h0);
        mem_latency = 0;
        push_exp(1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 32'hFFFF_0600);
        push_exp(1'b1, 1'b0, 32'h700, 32'h0, 4'h0, 32'hFFFF_0700);
        @(posedge clk); #1;
        fork
            apply_stimulus(0, 1'b0, 32'h600, 32'h0, 4'h0);
            apply_stimulus(1, 1'b0, 32'h700, 32'h0, 4'h0);
        join

        // Sixteen stall cycles are tolerated; seventeen trip the sticky flag.
        $display("[TB] wait limit");
        mem_latency = 16;
        push_exp(1'b0, 1'b0, 32'h800, 32'h0, 4'h0, 32'hFFFF_0800);
        @(posedge clk); #1;
        apply_stimulus(0, 1'b0, 32'h800, 32'h0, 4'h0);
        @(negedge clk);
        check_output("timeout_at_limit", 32'(timeout), 32'h0);
        mem_latency = 17;
        push_exp(1'b0, 1'b0, 32'h804, 32'h0, 4'h0, 32'hFFFF_0804);
        @(posedge clk); #1;
        apply_stimulus(0, 1'b0, 32'h804, 32'h0, 4'h0);
        @(negedge clk);
        check_output("timeout_over_limit", 32'(timeout), 32'h1);
        repeat (3) @(negedge clk);
        check_output("timeout_sticky", 32'(timeout), 32'h1);

        // Reset during an OWN1 wait abandons the transfer; the post-reset tie goes to m0.
        $display("[TB] reset mid-transfer");
        mem_latency = 10;
        @(posedge clk); #1;
        m1_valid = 1'b1; m1_addr = 32'h900;
        m1_ready_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'hA00;
        @(posedge clk);
        @(negedge clk);
        check_output("midreset_grant", 32'(grant), 32'h0);
        check_output("midreset_mem_valid", 32'(mem_valid), 32'h0);
        check_output("midreset_timeout", 32'(timeout), 32'h0);
        check_output("midreset_m1_ready", 32'(m1_ready_seen), 32'h0);
        mem_latency = 0;
        push_exp(1'b0, 1'b0, 32'hA00, 32'h0, 4'h0, 32'hFFFF_0A00);
        push_exp(1'b1, 1'b0, 32'h900, 32'h0, 4'h0, 32'hFFFF_0900);
        fork
            apply_stimulus(0, 1'b0, 32'hA00, 32'h0, 4'h0);
            apply_stimulus(1, 1'b0, 32'h900, 32'h0, 4'h0);
            begin
                @(posedge clk);
                #1 resetn = 1'b1;
            end
        join

        repeat (3) @(negedge clk);
        check_output("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
